// File: rtl/eth_test_frame_gen.sv
// eth_test_frame_gen: parametrised Ethernet test-frame source.
// Header, then an 8-byte tag and a selectable pattern, with count, IFG and stop.
module eth_test_frame_gen #(
  parameter int          DATA_WIDTH = 8,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int          LEN_WIDTH  = 11,
  parameter logic [15:0] ETH_TYPE   = 16'h88B5,
  parameter logic [7:0]  FLAG_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           packet_num,
  input  logic [LEN_WIDTH-1:0]  payload_len,
  input  logic [7:0]            ifg_cycles,
  input  logic [1:0]            mode,
  input  logic [7:0]            fill_byte,
  input  logic [47:0]           src_mac,
  input  logic [47:0]           dst_mac,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frames_sent
);

  localparam int             IW      = LEN_WIDTH + 1;
  localparam logic [IW-1:0]  KW      = IW'(KEEP_WIDTH);
  localparam logic [IW-1:0]  MIN_LEN = IW'(8);

  typedef enum logic [2:0] {
    IDLE, HDR, PAYLOAD, GAP, DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]   ts, ts_lat, seq, pkt_lat;
  logic [IW-1:0] idx, len_lat, len_in;
  logic [7:0]    ifg_lat, gap_cnt, fill_lat;
  logic [1:0]    mode_lat;
  logic [47:0]   src_lat, dst_lat;
  logic          stop_seen, stop_any;
  logic          hdr_fire, beat_fire;
  logic          last_beat, run_end;

  assign len_in = ({1'b0, payload_len} < MIN_LEN) ?
                  MIN_LEN : {1'b0, payload_len};

  assign stop_any  = stop_seen | stop;
  assign hdr_fire  = m_eth_hdr_valid & m_eth_hdr_ready;
  assign beat_fire = m_eth_payload_axis_tvalid &
                     m_eth_payload_axis_tready;
  assign last_beat = (idx + KW) >= len_lat;
  assign run_end   = ((pkt_lat != 16'd0) &&
                      (frames_sent + 16'd1 == pkt_lat)) ||
                     stop_any;

  function automatic logic [7:0] pay_byte(
    input logic [IW-1:0] k,
    input logic [15:0]   t,
    input logic [15:0]   s,
    input logic [1:0]    md,
    input logic [7:0]    fb
  );
    logic [7:0] d;
    d = k[7:0] - 8'd8;
    pay_byte = 8'h00;
    unique case (1'b1)
      k == IW'(0): pay_byte = FLAG_BYTE;
      k == IW'(1): pay_byte = t[15:8];
      k == IW'(2): pay_byte = t[7:0];
      k == IW'(6): pay_byte = s[15:8];
      k == IW'(7): pay_byte = s[7:0];
      k >= MIN_LEN: begin
        case (md)
          2'd1:    pay_byte = fb;
          2'd2:    pay_byte = d[0] ? 8'hAA : 8'h55;
          default: pay_byte = d;
        endcase
      end
      default: pay_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_nx                  = state;
    m_eth_hdr_valid           = 1'b0;
    m_eth_payload_axis_tvalid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = HDR;
      end
      HDR: begin
        m_eth_hdr_valid = 1'b1;
        if (m_eth_hdr_ready) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        m_eth_payload_axis_tvalid = 1'b1;
        if (m_eth_payload_axis_tready && last_beat) begin
          if (run_end)                state_nx = DONE;
          else if (ifg_lat == 8'd0)   state_nx = HDR;
          else                        state_nx = GAP;
        end
      end
      GAP: begin
        if (stop_any)               state_nx = DONE;
        else if (gap_cnt == 8'd0)   state_nx = HDR;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts          <= '0;
      ts_lat      <= '0;
      seq         <= '0;
      frames_sent <= '0;
      idx         <= '0;
      len_lat     <= MIN_LEN;
      pkt_lat     <= '0;
      ifg_lat     <= '0;
      gap_cnt     <= '0;
      fill_lat    <= '0;
      mode_lat    <= '0;
      src_lat     <= '0;
      dst_lat     <= '0;
      stop_seen   <= 1'b0;
    end else begin
      ts <= ts + 16'd1;
      if (state == IDLE) stop_seen <= 1'b0;
      else if (stop)     stop_seen <= 1'b1;
      if (state == IDLE && start) begin
        len_lat     <= len_in;
        pkt_lat     <= packet_num;
        ifg_lat     <= ifg_cycles;
        mode_lat    <= mode;
        fill_lat    <= fill_byte;
        src_lat     <= src_mac;
        dst_lat     <= dst_mac;
        seq         <= '0;
        frames_sent <= '0;
        idx         <= '0;
      end
      if (hdr_fire) begin
        ts_lat <= ts;
        idx    <= '0;
      end
      if (beat_fire) begin
        if (last_beat) begin
          idx         <= '0;
          seq         <= seq + 16'd1;
          frames_sent <= frames_sent + 16'd1;
          if (!run_end && ifg_lat != 8'd0)
            gap_cnt <= ifg_lat - 8'd1;
        end else begin
          idx <= idx + KW;
        end
      end
      if (state == GAP && gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;
    end
  end

  // lanes past the frame end stay zero with tkeep low
  always_comb begin
    m_eth_payload_axis_tdata = '0;
    m_eth_payload_axis_tkeep = '0;
    for (int l = 0; l < KEEP_WIDTH; l++) begin
      if (state == PAYLOAD && (idx + IW'(l)) < len_lat) begin
        m_eth_payload_axis_tkeep[l] = 1'b1;
        m_eth_payload_axis_tdata[8*l +: 8] =
          pay_byte(idx + IW'(l), ts_lat, seq, mode_lat, fill_lat);
      end
    end
  end

  assign m_eth_payload_axis_tlast = (state == PAYLOAD) && last_beat;
  assign m_eth_payload_axis_tuser = 1'b0;
  assign m_eth_dest_mac           = dst_lat;
  assign m_eth_src_mac            = src_lat;
  assign m_eth_type               = ETH_TYPE;
  assign busy                     = (state != IDLE);
  assign done                     = (state == DONE);

endmodule

// File: tb/tb_eth_test_frame_gen.sv
// tb_eth_test_frame_gen: directed bench for eth_test_frame_gen at 32 bits,
// checking every handshake against a byte-stream model of the frame format.
`timescale 1ns/1ps
module tb_eth_test_frame_gen;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   packet_num = '0;
  logic [LW-1:0] payload_len = '0;
  logic [7:0]    ifg_cycles = '0;
  logic [1:0]    mode = '0;
  logic [7:0]    fill_byte = '0;
  logic [47:0]   src_mac = 48'h02_11_22_33_44_55;
  logic [47:0]   dst_mac = 48'h02_66_77_88_99_AA;
  logic          hdr_valid;
  logic          hdr_ready = 1'b0;
  logic [47:0]   o_dst, o_src;
  logic [15:0]   o_type;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid, tlast, tuser;
  logic          tready = 1'b0;
  logic          busy, done;
  logic [15:0]   frames_sent;

  eth_test_frame_gen #(.DATA_WIDTH(DW)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .start                     (start),
    .stop                      (stop),
    .packet_num                (packet_num),
    .payload_len               (payload_len),
    .ifg_cycles                (ifg_cycles),
    .mode                      (mode),
    .fill_byte                 (fill_byte),
    .src_mac                   (src_mac),
    .dst_mac                   (dst_mac),
    .m_eth_hdr_valid           (hdr_valid),
    .m_eth_hdr_ready           (hdr_ready),
    .m_eth_dest_mac            (o_dst),
    .m_eth_src_mac             (o_src),
    .m_eth_type                (o_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tkeep  (tkeep),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser),
    .busy                      (busy),
    .done                      (done),
    .frames_sent               (frames_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // ready drivers: forced values, or coin flips in the stall test
  logic hr_req = 1'b0, tr_req = 1'b0, rnd_en = 1'b0;
  always @(posedge clk) begin
    #2;
    hdr_ready = rnd_en ? ($urandom_range(0, 1) == 1) : hr_req;
    tready    = rnd_en ? ($urandom_range(0, 1) == 1) : tr_req;
  end

  // free-running timestamp as the frame format defines it
  logic [15:0] tb_ts;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 16'd1;

  int          m_len, m_mode;
  logic [7:0]  m_fill;
  logic [15:0] m_seq;
  logic [47:0] m_src, m_dst;
  logic [7:0]  exp_q[$];
  logic [7:0]  strm[$];
  logic [7:0]  ref_q[$];
  logic [15:0] hdr_ts[$];
  int          gaps[$];
  int          pos, cyc, hdr_cnt, done_cnt, beat_cnt, frames_done;
  int          last_end_cyc;
  bit          in_frame;
  logic [KW-1:0] last_keep;
  logic [DW-1:0] last_data;
  bit          p_hstall, p_tstall;
  logic [47:0] p_dst, p_src;
  logic [DW-1:0] p_data;
  logic [KW-1:0] p_keep;
  logic        p_last;

  function automatic logic [7:0] exp_byte(int k, logic [15:0] t,
                                          logic [15:0] s);
    if (k == 0) return 8'hA5;
    if (k == 1) return t[15:8];
    if (k == 2) return t[7:0];
    if (k < 6)  return 8'h00;
    if (k == 6) return s[15:8];
    if (k == 7) return s[7:0];
    if (m_mode == 1) return m_fill;
    if (m_mode == 2) return ((k - 8) % 2 == 0) ? 8'h55 : 8'hAA;
    return 8'((k - 8) % 256);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
      p_hstall = 0;
      p_tstall = 0;
    end else begin
      logic [DW-1:0] ed;
      logic [KW-1:0] ek;
      cyc++;
      if (p_hstall) begin
        chk("hdr_valid_held", hdr_valid, 1);
        chk("hdr_dst_stable", o_dst, p_dst);
        chk("hdr_src_stable", o_src, p_src);
      end
      if (p_tstall) begin
        chk("tvalid_held", tvalid, 1);
        chk("tdata_stable", tdata, p_data);
        chk("tkeep_stable", tkeep, p_keep);
        chk("tlast_stable", tlast, p_last);
      end
      if (hdr_valid && hdr_ready) begin
        chk("hdr_in_frame", in_frame, 0);
        chk("hdr_dst", o_dst, m_dst);
        chk("hdr_src", o_src, m_src);
        chk("hdr_type", o_type, 16'h88B5);
        exp_q.delete();
        for (int k = 0; k < m_len; k++)
          exp_q.push_back(exp_byte(k, tb_ts, m_seq));
        hdr_ts.push_back(tb_ts);
        if (last_end_cyc >= 0) gaps.push_back(cyc - last_end_cyc - 1);
        m_seq++;
        hdr_cnt++;
        pos = 0;
        in_frame = 1;
      end
      if (tvalid && tready) begin
        chk("beat_after_hdr", in_frame, 1);
        chk("tuser", tuser, 0);
        if (in_frame) begin
          ed = '0;
          ek = '0;
          for (int l = 0; l < KW; l++) begin
            if (pos + l < m_len) begin
              ed[8*l +: 8] = exp_q[pos + l];
              ek[l] = 1'b1;
              strm.push_back(tdata[8*l +: 8]);
            end
          end
          chk("tdata", tdata, ed);
          chk("tkeep", tkeep, ek);
          chk("tlast", tlast, (pos + KW >= m_len));
          pos += KW;
          beat_cnt++;
          last_keep = tkeep;
          last_data = tdata;
          if (pos >= m_len) begin
            in_frame = 0;
            frames_done++;
            last_end_cyc = cyc;
          end
        end
      end
      if (done) done_cnt++;
      p_hstall = hdr_valid && !hdr_ready;
      p_dst = o_dst;
      p_src = o_src;
      p_tstall = tvalid && !tready;
      p_data = tdata;
      p_keep = tkeep;
      p_last = tlast;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(int len, int pkt, int md, logic [7:0] fb, int ifg);
    payload_len = LW'(len);
    packet_num  = 16'(pkt);
    mode        = 2'(md);
    fill_byte   = fb;
    ifg_cycles  = 8'(ifg);
    m_len  = (len < 8) ? 8 : len;
    m_mode = md;
    m_fill = fb;
    m_seq  = '0;
    m_src  = src_mac;
    m_dst  = dst_mac;
    strm.delete();
    gaps.delete();
    hdr_ts.delete();
    hdr_cnt = 0;
    done_cnt = 0;
    beat_cnt = 0;
    frames_done = 0;
    last_end_cyc = -1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", (done_cnt != 0), 1);
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int diffs, n;
    tick(3);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frames", frames_sent, 0);
    rst_n = 1'b1;
    tick(2);

    // two 12-byte frames, incrementing pattern, always ready
    hr_req = 1;
    tr_req = 1;
    run(12, 2, 0, 8'h00, 0);
    tick(1);
    chk("t1_busy_run", busy, 1);
    wait_done(200);
    chk("t1_bytes", strm.size(), 24);
    chk("t1_flag", strm[0], 8'hA5);
    chk("t1_ts", {strm[1], strm[2]}, hdr_ts[0]);
    for (int i = 3; i < 9; i++) chk("t1_zero", strm[i], 8'h00);
    chk("t1_pat1", strm[9], 8'h01);
    chk("t1_pat2", strm[10], 8'h02);
    chk("t1_pat3", strm[11], 8'h03);
    chk("t1_seq2_hi", strm[18], 8'h00);
    chk("t1_seq2_lo", strm[19], 8'h01);
    chk("t1_beats", beat_cnt, 6);
    chk("t1_gap", gaps[0], 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_frames", frames_sent, 2);
    chk("t1_busy_end", busy, 0);

    // 13 bytes of alternating pattern; MACs must be latched at start
    run(13, 1, 2, 8'h00, 0);
    src_mac = 48'hDE_AD_BE_EF_00_01;
    wait_done(200);
    chk("t2_bytes", strm.size(), 13);
    chk("t2_beats", beat_cnt, 4);
    chk("t2_b8", strm[8], 8'h55);
    chk("t2_b9", strm[9], 8'hAA);
    chk("t2_b10", strm[10], 8'h55);
    chk("t2_b11", strm[11], 8'hAA);
    chk("t2_b12", strm[12], 8'h55);
    chk("t2_last_keep", last_keep, 4'b0001);
    chk("t2_last_data", last_data, 32'h0000_0055);

    // short length rounds up to 8; header stalled five cycles
    hr_req = 0;
    run(3, 1, 0, 8'h00, 0);
    tick(5);
    chk("t3_hdr_waiting", hdr_valid, 1);
    chk("t3_no_fire", hdr_cnt, 0);
    hr_req = 1;
    wait_done(200);
    chk("t3_bytes", strm.size(), 8);
    chk("t3_beats", beat_cnt, 2);
    chk("t3_ts", {strm[1], strm[2]}, hdr_ts[0]);

    // fill pattern, always-ready reference versus random backpressure
    run(64, 2, 1, 8'h3C, 0);
    wait_done(400);
    ref_q = strm;
    rnd_en = 1;
    run(64, 2, 1, 8'h3C, 0);
    wait_done(3000);
    rnd_en = 0;
    tick(1);
    chk("t4_size", strm.size(), ref_q.size());
    diffs = 0;
    for (int i = 0; i < ref_q.size(); i++)
      if ((i % 64) != 1 && (i % 64) != 2 && strm[i] !== ref_q[i])
        diffs++;
    chk("t4_stream_diffs", diffs, 0);
    chk("t4_fill", strm[63], 8'h3C);
    chk("t4_flag2", strm[64], 8'hA5);
    chk("t4_seq2", strm[71], 8'h01);

    // continuous run with gap, stop during frame 3
    run(12, 0, 3, 8'h00, 4);
    n = 0;
    while (hdr_cnt < 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("t5_third_hdr", hdr_cnt, 3);
    #1;
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_done(200);
    tick(20);
    chk("t5_frames_done", frames_done, 3);
    chk("t5_no_hdr4", hdr_cnt, 3);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_frames_sent", frames_sent, 3);
    chk("t5_gap1", gaps[0], 4);
    chk("t5_gap2", gaps[1], 4);
    chk("t5_mode3", strm[11], 8'h03);
    chk("t5_busy", busy, 0);

    // asynchronous reset in the middle of a payload
    run(64, 1, 0, 8'h00, 0);
    n = 0;
    while (!tvalid && n < 50) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("t6_in_payload", tvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", tvalid, 0);
    chk("t6_rst_hdr", hdr_valid, 0);
    chk("t6_rst_tlast", tlast, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_frames", frames_sent, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run(8, 1, 0, 8'h00, 0);
    wait_done(200);
    chk("t6_bytes", strm.size(), 8);
    chk("t6_seq_hi", strm[6], 8'h00);
    chk("t6_seq_lo", strm[7], 8'h00);
    chk("t6_frames", frames_sent, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_test_frame_gen.md
Name: eth_test_frame_gen

Overview:
- Parametrised Ethernet test-frame source; successor to the 8-bit fixed-length pattern generator.
- Emits a header, then a payload: an 8-byte tag (flag, timestamp, zeros, sequence number) followed by a selectable data pattern.
- Supports configurable data width, payload length, frame count, inter-frame gap and graceful stop.
- Drives an eth_axis_tx-style header/payload interface for link bring-up and loopback tests.

Parameters:
- DATA_WIDTH, 8, payload bus width in bits; multiple of 8, range 8..64.
- KEEP_WIDTH, DATA_WIDTH/8, byte lanes.
- LEN_WIDTH, 11, width of payload_len.
- ETH_TYPE, 16'h88B5, value driven on m_eth_type.
- FLAG_BYTE, 8'hA5, payload byte 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  pulse in IDLE: latch config, begin run.
- stop  in  1  request end of run after the current frame.
- packet_num  in  16  frames per run; 0 = continuous.
- payload_len  in  LEN_WIDTH  payload bytes per frame; values <8 treated as 8.
- ifg_cycles  in  8  idle cycles between frames.
- mode  in  2  pattern: 0 incrementing, 1 fill_byte, 2 alternating 55/AA, 3 = mode 0.
- fill_byte  in  8  constant for mode 1.
- src_mac, dst_mac  in  48 each  header addresses (latched at start).
- m_eth_hdr_valid  out  1.  m_eth_hdr_ready  in  1.
- m_eth_dest_mac, m_eth_src_mac  out  48.  m_eth_type  out  16.
- m_eth_payload_axis_tdata  out  DATA_WIDTH.  m_eth_payload_axis_tkeep  out  KEEP_WIDTH.
- m_eth_payload_axis_tvalid  out  1.  m_eth_payload_axis_tready  in  1.
- m_eth_payload_axis_tlast  out  1.  m_eth_payload_axis_tuser  out  1, tied 0.
- busy  out  1  not IDLE.  done  out  1  one-cycle pulse at run end.
- frames_sent  out  16  frames completed this run; wraps.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all valids, tlast, busy, done = 0; frames_sent, seq, ts counter, byte index = 0.
- ts: free-running 16-bit counter, +1 every cycle, wraps.
- Handshake: hdr fire = hdr_valid & hdr_ready; beat fire = tvalid & tready. Outputs hold stable while valid & !ready. Payload never starts before its header fires.
- States:
  - IDLE: start -> latch config and MACs, seq=0, frames_sent=0 -> HDR. start outside IDLE ignored.
  - HDR: hdr_valid=1. On fire, capture ts into ts_lat -> PAYLOAD.
  - PAYLOAD: tvalid=1. Byte k of frame sits in lane k mod KEEP_WIDTH, lane 0 = bits [7:0].
  - Byte map:
    - 0 = FLAG_BYTE.
    - 1,2 = ts_lat[15:8], ts_lat[7:0].
    - 3..5 = 0.
    - 6,7 = seq[15:8], seq[7:0].
    - k>=8: mode0 (k-8) mod 256; mode1 fill_byte; mode2 55 when (k-8) even, else AA.
  - tlast on the beat containing byte len-1. tkeep low-aligned ones for valid bytes; all ones except on the last beat. Unused lanes drive 0.
  - Last beat fire: seq+1, frames_sent+1. If (packet_num!=0 and frames_sent+1==packet_num) or stop seen -> DONE. Else ifg_cycles==0 -> HDR, otherwise GAP.
  - GAP: count ifg_cycles cycles, then HDR. stop seen -> DONE immediately.
  - DONE: done=1 for one cycle -> IDLE.
- stop is sticky once sampled high while busy; cleared on entering IDLE.
- Frame beats = ceil(len/KEEP_WIDTH). Index arithmetic uses LEN_WIDTH+1 bits, no overflow.
- seq and frames_sent wrap 16'hFFFF->0.

Test Plan:
- DATA_WIDTH=8, len=12, packet_num=2, mode0, ifg=0, ready=1 -> frame1: A5,tsH,tsL,00,00,00,00,00,00,01,02,03, tlast on byte 12; frame2 seq bytes 00,01; done pulses once; frames_sent=2.
- DATA_WIDTH=32, len=13, mode2 -> 4 beats; beat2 = 55,AA,55,AA low-to-high; last beat tkeep=4'b0001, byte 55, other lanes 0.
- len=3 -> treated as 8: 8 bytes, tlast on byte 8. hdr_ready held low 5 cycles -> header outputs stable; ts bytes = counter value at fire.
- Random tready/hdr_ready, 8-bit, mode1 fill=3C, len=64 -> byte stream identical to always-ready run; no beat changes while stalled.
- packet_num=0, ifg=4, assert stop mid-frame 3 -> frame 3 completes with tlast; no header 4; done pulses; busy drops. Exactly 4 idle cycles between frames 1 and 2.
- rst_n low mid-payload -> valids low immediately; after release, start -> new run with seq=0.
